mul_seq_unit: RTL

//  Iterative 32x32 multiplier for the MIPS CPU execute stage. It sits directly

---
 rtl/mul_seq_unit_pkg.sv | 17 +
 rtl/mul_seq_unit_pp_sel.sv | 27 ++
 rtl/mul_seq_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the iterative multiplier and the instruction decoder.
// Holds the default operand width, the multiplier FSM state encoding and the
// MULT/MULTU funct codes so decoder and execute stage agree on them.
package mul_seq_unit_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_CALC = 2'd1,
    MUL_FIX  = 2'd2
  } mul_state_e;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mul_seq_unit_pp_sel.sv
// Radix-4 partial-product selector.
// Ports:
//   sel_i  2 multiplier bits of the current step
//   m_i    multiplicand magnitude
//   m3_i   precomputed 3*m_i
//   pp_o   0 / M / 2M / 3M, WIDTH+2 bits
module mul_seq_unit_pp_sel #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH+1:0] m3_i,
  output logic [WIDTH+1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    unique case (sel_i)
      2'd0: pp_o = '0;
      2'd1: pp_o = {2'b00, m_i};
      2'd2: pp_o = {1'b0, m_i, 1'b0};
      2'd3: pp_o = m3_i;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative WIDTH x WIDTH multiplier, radix-4 shift-add (2 multiplier bits per
// clock). Operands are converted to magnitudes at load, the product sign is
// applied in a final FIX cycle, so a result takes ITER+1 clocks after START.
// Ports:
//   clk_i      fast core clock
//   rst_ni     asynchronous active-low reset
//   start_i    request, sampled only in IDLE
//   signed_i   1 = two's complement (MULT), 0 = unsigned (MULTU)
//   a_i, b_i   operands, sampled with an accepted start_i
//   busy_o     high from the cycle after acceptance until done_o
//   done_o     one-cycle pulse, product valid
//   p_hi_o     product upper half (to HI)
//   p_lo_o     product lower half (to LO / writeBack)
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] p_hi_o,
  output logic [WIDTH-1:0] p_lo_o
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int AW   = 2 * WIDTH + 2;

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH+1:0]   m3_q, m3_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH+1:0]   pp;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [CW-1:0]      step;
  logic               unused_acc_hi;

  mul_seq_unit_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .sel_i (b_q[1:0]),
    .m_i   (m_q),
    .m3_i  (m3_q),
    .pp_o  (pp)
  );

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiplier is consumed LSB-first; step counts up while cnt counts down.
  assign step = CW'(ITER - 1) - cnt_q;

  // Headroom bits of the accumulator never reach the outputs.
  assign unused_acc_hi = ^acc_q[AW-1:2*WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MUL_IDLE;
      m_q     <= '0;
      m3_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      m3_q    <= m3_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    m3_d    = m3_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;

    unique case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          m_d     = a_mag;
          m3_d    = {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
          b_d     = b_mag;
          neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CW'(ITER - 1);
          busy_d  = 1'b1;
          state_d = MUL_CALC;
        end
      end
      MUL_CALC: begin
        acc_d = acc_q + ({{WIDTH{1'b0}}, pp} << {step, 1'b0});
        b_d   = b_q >> 2;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = MUL_FIX;
        end
      end
      MUL_FIX: begin
        // Negating a zero magnitude yields zero, so 0 * negative never gives -0.
        p_d     = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_hi_o = p_q[2*WIDTH-1:WIDTH];
  assign p_lo_o = p_q[WIDTH-1:0];

endmodule
